// File: rtl/fp_accumulate_ctrl.sv
// Sequential IEEE-754 single-precision accumulator controller.
// Feeds one add/sub per term to an external combinational FP unit and emits the running sum.
module fp_accumulate_ctrl #(
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_exc,
    output logic             out_trunc,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_sub,
    input  logic [31:0]      add_result,
    input  logic             add_exc
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           r_state;
    logic [31:0]      r_acc;
    logic [31:0]      r_opb;
    logic             r_sub;
    logic             r_last;
    logic             r_exc;
    logic             r_trunc;
    logic [CNT_W-1:0] r_count;
    logic             r_in_ready;
    logic             r_out_valid;

    logic w_accept;
    logic w_at_limit;

    assign w_accept   = in_valid & r_in_ready;
    // The term being accepted now is the one that fills the last slot.
    assign w_at_limit = (r_count == CNT_W'(MAX_TERMS - 1));

    // NOTE: handshake outputs are registers, so after reset in_ready stays low for one
    // full cycle and the adder operands never see in_* combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_opb       <= '0;
            r_sub       <= 1'b0;
            r_last      <= 1'b0;
            r_exc       <= 1'b0;
            r_trunc     <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_opb      <= in_data;
                        r_sub      <= in_sub;
                        r_last     <= in_last | w_at_limit;
                        r_trunc    <= ~in_last & w_at_limit;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD;
                    end
                end
                ADD: begin
                    // An excepting add returns 0; that value is kept and the stream goes on.
                    r_acc   <= add_result;
                    r_exc   <= r_exc | add_exc;
                    r_count <= r_count + 1'b1;
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_exc       <= 1'b0;
                        r_trunc     <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_acc;
    assign out_count = r_count;
    assign out_exc   = r_exc;
    assign out_trunc = r_trunc;
    assign add_a     = r_acc;
    assign add_b     = r_opb;
    assign add_sub   = r_sub;

endmodule
